// File: rtl/muldiv_ctrl.sv
// Multi-cycle MIPS multiply/divide sequencer owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a sign-fix state.
module muldiv_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]          state;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] acc;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [DATA_W-1:0]   divisor;  // divisor, or multiplicand for multiply
    logic                is_div;
    logic                neg_lo;   // sign of product or quotient
    logic                neg_hi;   // sign of remainder

    logic                signed_op;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     div_trial;
    logic [DATA_W:0]     div_diff;
    logic                div_fits;
    logic [2*DATA_W-1:0] div_next;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign busy = (state == S_RUN) || (state == S_FIX);

    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        signed_op = 1'b0;
        a_neg     = 1'b0;
        b_neg     = 1'b0;
        a_mag     = op_a;
        b_mag     = op_b;
        mul_sum   = '0;
        mul_next  = '0;
        div_trial = '0;
        div_diff  = '0;
        div_fits  = 1'b0;
        div_next  = '0;
        prod_fix  = acc;
        quot_fix  = acc[DATA_W-1:0];
        rem_fix   = acc[2*DATA_W-1:DATA_W];

        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op && op_a[DATA_W-1];
        b_neg     = signed_op && op_b[DATA_W-1];
        a_mag     = a_neg ? (~op_a + 1'b1) : op_a;
        b_mag     = b_neg ? (~op_b + 1'b1) : op_b;

        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, divisor} : '0);
        mul_next  = {mul_sum, acc[DATA_W-1:1]};

        // Remainder is always below the divisor, so the shifted trial fits in DATA_W+1 bits.
        div_trial = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        div_diff  = div_trial - {1'b0, divisor};
        div_fits  = !div_diff[DATA_W];
        div_next  = {(div_fits ? div_diff[DATA_W-1:0] : div_trial[DATA_W-1:0]),
                     acc[DATA_W-2:0], div_fits};

        if (neg_lo) begin
            prod_fix = ~acc + 1'b1;
            quot_fix = ~acc[DATA_W-1:0] + 1'b1;
        end
        if (neg_hi) begin
            rem_fix = ~acc[2*DATA_W-1:DATA_W] + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            acc      <= '0;
            divisor  <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            if (op[1] && (op_b == '0)) begin
                                lo       <= '1;
                                hi       <= op_a;
                                done     <= 1'b1;
                                div_zero <= 1'b1;
                            end else begin
                                state   <= S_RUN;
                                count   <= '0;
                                is_div  <= op[1];
                                acc     <= {{DATA_W{1'b0}}, a_mag};
                                divisor <= b_mag;
                                neg_lo  <= a_neg ^ b_neg;
                                neg_hi  <= a_neg;
                            end
                        end else if (op == OP_MTHI) begin
                            hi <= op_a;
                        end else if (op == OP_MTLO) begin
                            lo <= op_a;
                        end
                    end
                end
                S_RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    if (count == LAST) begin
                        state <= S_FIX;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        lo <= quot_fix;
                        hi <= rem_fix;
                    end else begin
                        lo <= prod_fix[DATA_W-1:0];
                        hi <= prod_fix[2*DATA_W-1:DATA_W];
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
